// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load size encodings, datapath widths and the
// fixed register-file control constants driven by the write-back stage.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [1:0] RF_BYTE_WORD = 2'b11;
  localparam logic       RF_SIGNED    = 1'b0;

endpackage

// File: rtl/mem_wb_writeback_load_extend.sv
// Combinational load lane extraction and sign/zero extension for
// little-endian byte, halfword and word loads, plus alignment detection.
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsi_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic        byteSign;
  logic        halfSign;

  always_comb begin
    byteLane = 8'h00;
    case (addr_i)
      2'd0:    byteLane = word_i[7:0];
      2'd1:    byteLane = word_i[15:8];
      2'd2:    byteLane = word_i[23:16];
      default: byteLane = word_i[31:24];
    endcase
  end

  assign halfLane = addr_i[1] ? word_i[31:16] : word_i[15:0];
  assign byteSign = ~unsi_i & byteLane[7];
  assign halfSign = ~unsi_i & halfLane[15];

  // Size 00 falls into the word branch on purpose.
  always_comb begin
    data_o       = word_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        data_o       = {{24{byteSign}}, byteLane};
        misaligned_o = 1'b0;
      end
      SZ_HALF: begin
        data_o       = {{16{halfSign}}, halfLane};
        misaligned_o = addr_i[0];
      end
      default: begin
        data_o       = word_i;
        misaligned_o = |addr_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register: selects ALU or extracted load result, drives the
// register-file write port and WB forwarding source, counts retirements.
module mem_wb_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic              mem_memtoreg,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_aluresult,
  input  logic [DATA_W-1:0] mem_loaddata,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsi,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic              writereg,
  output logic [REG_AW-1:0] rtd,
  output logic [DATA_W-1:0] writedata,
  output logic [1:0]        rf_byte,
  output logic              rf_unsi,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retire_count
);

  logic              valid_q,     valid_d;
  logic              writereg_q,  writereg_d;
  logic [REG_AW-1:0] rtd_q,       rtd_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              misalign_q,  misalign_d;
  logic [CNT_W-1:0]  count_q,     count_d;

  logic [31:0]       loadData;
  logic              loadMisaligned;
  logic              badLoad;
  logic [DATA_W-1:0] result;

  load_extend u_load_extend (
    .word_i       (mem_loaddata),
    .addr_i       (mem_aluresult[1:0]),
    .size_i       (mem_size),
    .unsi_i       (mem_unsi),
    .data_o       (loadData),
    .misaligned_o (loadMisaligned)
  );

  // Only a real load can be misaligned; ALU results ignore the low bits.
  assign badLoad = mem_valid & mem_memtoreg & loadMisaligned;
  assign result  = mem_memtoreg ? loadData : mem_aluresult;

  always_comb begin
    valid_d     = valid_q;
    writereg_d  = writereg_q;
    rtd_d       = rtd_q;
    writedata_d = writedata_q;
    misalign_d  = 1'b0;
    count_d     = count_q;
    if (wb_flush) begin
      valid_d    = 1'b0;
      writereg_d = 1'b0;
    end else if (!wb_stall) begin
      valid_d     = mem_valid;
      writereg_d  = mem_valid & mem_regwrite & (|mem_rd) & ~badLoad;
      rtd_d       = mem_rd;
      writedata_d = result;
      misalign_d  = badLoad;
      if (mem_valid) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      writereg_q  <= 1'b0;
      rtd_q       <= '0;
      writedata_q <= '0;
      misalign_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      writereg_q  <= writereg_d;
      rtd_q       <= rtd_d;
      writedata_q <= writedata_d;
      misalign_q  <= misalign_d;
      count_q     <= count_d;
    end
  end

  assign writereg     = writereg_q;
  assign rtd          = rtd_q;
  assign writedata    = writedata_q;
  assign misalign_err = misalign_q;
  assign retire_count = count_q;
  assign rf_byte      = RF_BYTE_WORD;
  assign rf_unsi      = RF_SIGNED;
  assign fwd_valid    = writereg_q;
  assign fwd_rd       = rtd_q;
  assign fwd_data     = writedata_q;

  logic unusedValid;
  assign unusedValid = valid_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: a vector table for single-cycle
// behaviour plus hand sequences for stall, flush, wrap and reset-in-stall.
module tb_mem_wb_writeback;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] load;
    logic [1:0]  size;
    logic        unsi;
    logic        stall;
    logic        flush;
    logic        rstn;
    logic        expWr;
    logic [4:0]  expRd;
    logic [31:0] expData;
    logic        expMis;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0, mem_regwrite = 1'b0, mem_memtoreg = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_aluresult = '0, mem_loaddata = '0;
  logic [1:0]  mem_size = 2'b11;
  logic        mem_unsi = 1'b0, wb_stall = 1'b0, wb_flush = 1'b0;
  logic        writereg, rf_unsi, fwd_valid, misalign_err;
  logic [4:0]  rtd, fwd_rd;
  logic [31:0] writedata, fwd_data, retire_count;
  logic [1:0]  rf_byte;

  int          total = 0;
  int          bad = 0;
  int          step = 0;
  logic [31:0] expCnt = '0;
  exp_t        expQ[$];
  vec_t        table_v[16];

  mem_wb_writeback #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_rd(mem_rd), .mem_aluresult(mem_aluresult), .mem_loaddata(mem_loaddata),
    .mem_size(mem_size), .mem_unsi(mem_unsi), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .writereg(writereg), .rtd(rtd), .writedata(writedata),
    .rf_byte(rf_byte), .rf_unsi(rf_unsi),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .misalign_err(misalign_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(logic v, logic rw, logic m2r, logic [4:0] rd,
                              logic [31:0] alu, logic [31:0] ld, logic [1:0] sz,
                              logic un, logic st, logic fl, logic rn,
                              logic ewr, logic [4:0] erd, logic [31:0] ed, logic emis);
    vec_t r;
    r.valid = v; r.regwrite = rw; r.memtoreg = m2r; r.rd = rd;
    r.alu = alu; r.load = ld; r.size = sz; r.unsi = un;
    r.stall = st; r.flush = fl; r.rstn = rn;
    r.expWr = ewr; r.expRd = erd; r.expData = ed; r.expMis = emis;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL step%0d %s: got %h want %h", step, name, act, want);
    end
  endtask

  // Drive one cycle of inputs and record what the registered outputs must be.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    mem_valid = v.valid; mem_regwrite = v.regwrite; mem_memtoreg = v.memtoreg;
    mem_rd = v.rd; mem_aluresult = v.alu; mem_loaddata = v.load;
    mem_size = v.size; mem_unsi = v.unsi;
    wb_stall = v.stall; wb_flush = v.flush; reset = v.rstn;
    if (!v.rstn) expCnt = '0;
    else if (!v.flush && !v.stall && v.valid) expCnt = expCnt + 32'd1;
    e.wr = v.expWr; e.rd = v.expRd; e.data = v.expData; e.mis = v.expMis; e.cnt = expCnt;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      total++; bad++;
      $display("[TB] FAIL step%0d scoreboard: got empty want entry", step);
    end else begin
      e = expQ.pop_front();
      cmp("writereg",     32'(writereg),     32'(e.wr));
      cmp("rtd",          32'(rtd),          32'(e.rd));
      cmp("writedata",    writedata,         e.data);
      cmp("misalign_err", 32'(misalign_err), 32'(e.mis));
      cmp("retire_count", retire_count,      e.cnt);
      cmp("fwd_valid",    32'(fwd_valid),    32'(e.wr));
      cmp("fwd_rd",       32'(fwd_rd),       32'(e.rd));
      cmp("fwd_data",     fwd_data,          e.data);
      cmp("rf_byte",      32'(rf_byte),      32'h3);
      cmp("rf_unsi",      32'(rf_unsi),      32'h0);
    end
    step++;
    @(negedge clk);
  endtask

  initial begin
    //            v rw m2r rd     alu            load          sz    un st fl rn  wr rd     data          mis
    table_v[0]  = mk(1, 1, 0, 5'd8,  32'h12345678, 32'h0,        2'b11, 0, 0, 0, 1, 1, 5'd8,  32'h12345678, 0);
    table_v[1]  = mk(1, 1, 1, 5'd3,  32'h00001003, 32'h80FF7F01, 2'b01, 0, 0, 0, 1, 1, 5'd3,  32'hFFFFFF80, 0);
    table_v[2]  = mk(1, 1, 1, 5'd3,  32'h00001003, 32'h80FF7F01, 2'b01, 1, 0, 0, 1, 1, 5'd3,  32'h00000080, 0);
    table_v[3]  = mk(1, 1, 1, 5'd4,  32'h00001001, 32'h80FF7F01, 2'b01, 0, 0, 0, 1, 1, 5'd4,  32'h0000007F, 0);
    table_v[4]  = mk(1, 1, 1, 5'd5,  32'h00001000, 32'h80FF7F01, 2'b01, 0, 0, 0, 1, 1, 5'd5,  32'h00000001, 0);
    table_v[5]  = mk(1, 1, 1, 5'd6,  32'h00001002, 32'h80FF7F01, 2'b01, 1, 0, 0, 1, 1, 5'd6,  32'h000000FF, 0);
    table_v[6]  = mk(1, 1, 1, 5'd7,  32'h00002002, 32'h9ABC0000, 2'b10, 0, 0, 0, 1, 1, 5'd7,  32'hFFFF9ABC, 0);
    table_v[7]  = mk(1, 1, 1, 5'd9,  32'h00002000, 32'h00008001, 2'b10, 1, 0, 0, 1, 1, 5'd9,  32'h00008001, 0);
    table_v[8]  = mk(1, 1, 1, 5'd10, 32'h00002001, 32'h9ABC0000, 2'b10, 0, 0, 0, 1, 0, 5'd10, 32'h00000000, 1);
    table_v[9]  = mk(1, 1, 1, 5'd11, 32'h00003000, 32'hCAFEBABE, 2'b11, 0, 0, 0, 1, 1, 5'd11, 32'hCAFEBABE, 0);
    table_v[10] = mk(1, 1, 1, 5'd12, 32'h00003002, 32'hCAFEBABE, 2'b11, 0, 0, 0, 1, 0, 5'd12, 32'hCAFEBABE, 1);
    table_v[11] = mk(1, 1, 1, 5'd13, 32'h00003000, 32'h13579BDF, 2'b00, 0, 0, 0, 1, 1, 5'd13, 32'h13579BDF, 0);
    table_v[12] = mk(1, 1, 0, 5'd0,  32'h00000055, 32'h0,        2'b11, 0, 0, 0, 1, 0, 5'd0,  32'h00000055, 0);
    table_v[13] = mk(0, 1, 0, 5'd14, 32'h00000066, 32'h0,        2'b11, 0, 0, 0, 1, 0, 5'd14, 32'h00000066, 0);
    table_v[14] = mk(1, 0, 0, 5'd15, 32'h00000077, 32'h0,        2'b11, 0, 0, 0, 1, 0, 5'd15, 32'h00000077, 0);
    table_v[15] = mk(1, 1, 0, 5'd16, 32'h00000003, 32'h0,        2'b10, 0, 0, 0, 1, 1, 5'd16, 32'h00000003, 0);

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(mk(1, 1, 0, 5'd8, 32'h12345678, 32'h0, 2'b11, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0));
      checkOutput();
    end

    for (int i = 0; i < 16; i++) begin
      applyStimulus(table_v[i]);
      checkOutput();
    end

    // Stall after a valid load: outputs and count frozen for three cycles.
    applyStimulus(mk(1, 1, 1, 5'd5, 32'h00004000, 32'hDEADBEEF, 2'b11, 0, 0, 0, 1, 1, 5'd5, 32'hDEADBEEF, 0));
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(1, 1, 0, 5'd9, 32'h11111111, 32'h0, 2'b11, 0, 1, 0, 1, 1, 5'd5, 32'hDEADBEEF, 0));
      checkOutput();
    end

    // Misaligned half load then stall: error must not re-pulse.
    applyStimulus(mk(1, 1, 1, 5'd6, 32'h00000001, 32'h0000ABCD, 2'b10, 0, 0, 0, 1, 0, 5'd6, 32'hFFFFABCD, 1));
    checkOutput();
    applyStimulus(mk(1, 1, 0, 5'd9, 32'h22222222, 32'h0, 2'b11, 0, 1, 0, 1, 0, 5'd6, 32'hFFFFABCD, 0));
    checkOutput();

    // Flush beats stall, and a flushed valid instruction neither writes nor counts.
    applyStimulus(mk(1, 1, 0, 5'd7, 32'h0000A5A5, 32'h0, 2'b11, 0, 0, 0, 1, 1, 5'd7, 32'h0000A5A5, 0));
    checkOutput();
    applyStimulus(mk(1, 1, 0, 5'd9, 32'h33333333, 32'h0, 2'b11, 0, 1, 1, 1, 0, 5'd7, 32'h0000A5A5, 0));
    checkOutput();
    applyStimulus(mk(1, 1, 0, 5'd10, 32'h000000BB, 32'h0, 2'b11, 0, 0, 1, 1, 0, 5'd7, 32'h0000A5A5, 0));
    checkOutput();

    // Counter wrap: preset to all-ones while stalled, then one valid capture.
    force dut.count_q = 32'hFFFFFFFF;
    expCnt = 32'hFFFFFFFF;
    applyStimulus(mk(1, 1, 0, 5'd9, 32'h44444444, 32'h0, 2'b11, 0, 1, 0, 1, 0, 5'd7, 32'h0000A5A5, 0));
    checkOutput();
    release dut.count_q;
    applyStimulus(mk(1, 1, 0, 5'd3, 32'h00000001, 32'h0, 2'b11, 0, 0, 0, 1, 1, 5'd3, 32'h00000001, 0));
    checkOutput();

    // Reset arriving mid-stall clears everything.
    applyStimulus(mk(1, 1, 0, 5'd2, 32'h00000022, 32'h0, 2'b11, 0, 0, 0, 1, 1, 5'd2, 32'h00000022, 0));
    checkOutput();
    applyStimulus(mk(1, 1, 0, 5'd9, 32'h55555555, 32'h0, 2'b11, 0, 1, 0, 1, 1, 5'd2, 32'h00000022, 0));
    checkOutput();
    applyStimulus(mk(1, 1, 0, 5'd9, 32'h55555555, 32'h0, 2'b11, 0, 1, 0, 0, 0, 5'd0, 32'h0, 0));
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
